// File: rtl/fetch_pc_queue.sv
// fetch_pc_queue: FIFO of fetch packets between the next-PC generator and
// the I-cache request stage. Each packet holds two PCs, a slot mask and
// predictor metadata. A redirect flush empties the queue in one cycle.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   flush_i         redirect, discards all entries
//   in_valid_i      packet offered (in_pc_i, in_mask_i, in_meta_i)
//   in_ready_o      queue not full
//   out_valid_o     head available (out_pc_o, out_mask_o, out_meta_o)
//   out_ready_i     consumer takes the head
//   count_o         occupied entries
module fetch_pc_queue #(
   parameter int DEPTH      = 4,
   parameter int META_WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   input  logic [1:0][31:0]         in_pc_i,
   input  logic [1:0]               in_mask_i,
   input  logic [META_WIDTH-1:0]    in_meta_i,
   output logic                     in_ready_o,
   output logic                     out_valid_o,
   output logic [1:0][31:0]         out_pc_o,
   output logic [1:0]               out_mask_o,
   output logic [META_WIDTH-1:0]    out_meta_o,
   input  logic                     out_ready_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [1:0][31:0]      pc;
      logic [1:0]            mask;
      logic [META_WIDTH-1:0] meta;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   entry_t        head;

   // Ready depends on registered count only: a full queue refuses a
   // push even if the head is popped in the same cycle.
   assign in_ready_o  = (count != CW'(DEPTH));
   assign out_valid_o = (count != '0);
   assign count_o     = count;

   assign push = in_valid_i && in_ready_o
              && (in_mask_i != 2'b00) && !flush_i;
   assign pop  = out_valid_o && out_ready_i && !flush_i;

   assign head       = mem[rd_ptr];
   assign out_pc_o   = head.pc;
   assign out_mask_o = head.mask;
   assign out_meta_o = head.meta;

   // Pointers are AW bits wide; DEPTH is a power of two so they wrap
   // naturally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{pc: in_pc_i,
                             mask: in_mask_i,
                             meta: in_meta_i};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Slot 1 without slot 0 is illegal from the next-PC stage.
   always_ff @(posedge clk) begin
      if (rst_n && !flush_i && in_valid_i) begin
         assert (in_mask_i != 2'b10)
            else $error("fetch_pc_queue: illegal mask 2'b10");
      end
   end

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Self-checking bench for fetch_pc_queue: scoreboard of accepted packets,
// compared against the head whenever the bench consumes it.
module tb_fetch_pc_queue;

   typedef struct packed {
      logic [1:0][31:0] pc;
      logic [1:0]       mask;
      logic [63:0]      meta;
   } pkt_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush_i;
   logic              in_valid_i;
   logic [1:0][31:0]  in_pc_i;
   logic [1:0]        in_mask_i;
   logic [63:0]       in_meta_i;
   logic              in_ready_o;
   logic              out_valid_o;
   logic [1:0][31:0]  out_pc_o;
   logic [1:0]        out_mask_o;
   logic [63:0]       out_meta_o;
   logic              out_ready_i;
   logic [2:0]        count_o;

   int   checks = 0;
   int   failures = 0;
   pkt_t sb[$];
   pkt_t got;
   pkt_t exp_p;

   fetch_pc_queue #(.DEPTH(4), .META_WIDTH(64)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush_i(flush_i),
      .in_valid_i(in_valid_i),
      .in_pc_i(in_pc_i),
      .in_mask_i(in_mask_i),
      .in_meta_i(in_meta_i),
      .in_ready_o(in_ready_o),
      .out_valid_o(out_valid_o),
      .out_pc_o(out_pc_o),
      .out_mask_o(out_mask_o),
      .out_meta_o(out_meta_o),
      .out_ready_i(out_ready_i),
      .count_o(count_o)
   );

   always #5 clk = ~clk;

   assign got = '{pc: out_pc_o, mask: out_mask_o, meta: out_meta_o};

   function automatic pkt_t mk(input int i);
      pkt_t p;
      p.pc[0] = 32'h1c00_1000 + 32'(i) * 8;
      p.pc[1] = p.pc[0] + 4;
      p.mask  = 2'b11;
      p.meta  = {32'hC0DE_0000 | 32'(i), ~32'(i)};
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic put(input bit v, input pkt_t p,
                      input bit rdy, input bit fl);
      in_valid_i  = v;
      in_pc_i     = p.pc;
      in_mask_i   = p.mask;
      in_meta_i   = p.meta;
      out_ready_i = rdy;
      flush_i     = fl;
   endtask

   task automatic idle();
      put(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      rst_n = 1'b1;
      checks++;
      if (count_o !== 3'd0) begin
         failures++;
         $display("FAIL reset_count got=%0d exp=0", count_o);
      end
      checks++;
      if (out_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid got=%b exp=0", out_valid_o);
      end
      checks++;
      if (in_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%b exp=1", in_ready_o);
      end
      checks++;
      if (got !== pkt_t'('0)) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0", got);
      end
   endtask

   task automatic test_single();
      pkt_t p;
      p.pc[0] = 32'h1c00_0000;
      p.pc[1] = 32'h1c00_0004;
      p.mask  = 2'b11;
      p.meta  = 64'hA5;
      put(1'b1, p, 1'b0, 1'b0);
      sb.push_back(p);
      checks++;
      if (out_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL single_no_bypass got=%b exp=0", out_valid_o);
      end
      tick();
      idle();
      checks++;
      if (out_valid_o !== 1'b1 || count_o !== 3'd1) begin
         failures++;
         $display("FAIL single_valid got=%b/%0d exp=1/1",
                  out_valid_o, count_o);
      end
      out_ready_i = 1'b1;
      exp_p = sb.pop_front();
      checks++;
      if (got !== exp_p) begin
         failures++;
         $display("FAIL single_data got=%h exp=%h", got, exp_p);
      end
      tick();
      idle();
      checks++;
      if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL single_drain got=%0d/%b exp=0/0",
                  count_o, out_valid_o);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         put(1'b1, mk(i), 1'b0, 1'b0);
         sb.push_back(mk(i));
         tick();
      end
      idle();
      checks++;
      if (count_o !== 3'd4 || in_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL fill_full got=%0d/%b exp=4/0",
                  count_o, in_ready_o);
      end
      // Full queue refuses the push even with a concurrent pop.
      put(1'b1, mk(99), 1'b1, 1'b0);
      exp_p = sb.pop_front();
      checks++;
      if (got !== exp_p) begin
         failures++;
         $display("FAIL fill_pop0 got=%h exp=%h", got, exp_p);
      end
      tick();
      idle();
      checks++;
      if (count_o !== 3'd3) begin
         failures++;
         $display("FAIL fill_refuse got=%0d exp=3", count_o);
      end
      for (int i = 0; i < 3; i++) begin
         out_ready_i = 1'b1;
         exp_p = sb.pop_front();
         checks++;
         if (out_valid_o !== 1'b1 || got !== exp_p) begin
            failures++;
            $display("FAIL fill_order%0d got=%h exp=%h", i, got, exp_p);
         end
         tick();
      end
      idle();
      checks++;
      if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL fill_empty got=%0d/%b exp=0/0",
                  count_o, out_valid_o);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 10; i < 12; i++) begin
         put(1'b1, mk(i), 1'b0, 1'b0);
         sb.push_back(mk(i));
         tick();
      end
      for (int i = 12; i < 22; i++) begin
         put(1'b1, mk(i), 1'b1, 1'b0);
         exp_p = sb.pop_front();
         sb.push_back(mk(i));
         checks++;
         if (got !== exp_p) begin
            failures++;
            $display("FAIL b2b_data%0d got=%h exp=%h", i, got, exp_p);
         end
         tick();
         checks++;
         if (count_o !== 3'd2) begin
            failures++;
            $display("FAIL b2b_count%0d got=%0d exp=2", i, count_o);
         end
      end
      for (int i = 0; i < 2; i++) begin
         put(1'b0, '0, 1'b1, 1'b0);
         exp_p = sb.pop_front();
         checks++;
         if (got !== exp_p) begin
            failures++;
            $display("FAIL b2b_drain%0d got=%h exp=%h", i, got, exp_p);
         end
         tick();
      end
      idle();
   endtask

   task automatic test_flush();
      for (int i = 30; i < 33; i++) begin
         put(1'b1, mk(i), 1'b0, 1'b0);
         tick();
      end
      put(1'b1, mk(40), 1'b1, 1'b1);
      tick();
      idle();
      sb.delete();
      checks++;
      if (count_o !== 3'd0 || out_valid_o !== 1'b0 ||
          in_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL flush_state got=%0d/%b/%b exp=0/0/1",
                  count_o, out_valid_o, in_ready_o);
      end
      tick();
      checks++;
      if (out_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_no_ghost got=%b exp=0", out_valid_o);
      end
      put(1'b1, mk(41), 1'b0, 1'b0);
      sb.push_back(mk(41));
      tick();
      put(1'b0, '0, 1'b1, 1'b0);
      exp_p = sb.pop_front();
      checks++;
      if (count_o !== 3'd1 || got !== exp_p) begin
         failures++;
         $display("FAIL flush_after got=%h exp=%h", got, exp_p);
      end
      tick();
      idle();
   endtask

   task automatic test_bubble();
      pkt_t p;
      p = mk(50);
      p.mask = 2'b00;
      put(1'b1, p, 1'b0, 1'b0);
      tick();
      idle();
      checks++;
      if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL bubble_ignored got=%0d/%b exp=0/0",
                  count_o, out_valid_o);
      end
      p = mk(51);
      p.mask = 2'b01;
      put(1'b1, p, 1'b0, 1'b0);
      sb.push_back(p);
      tick();
      put(1'b0, '0, 1'b1, 1'b0);
      exp_p = sb.pop_front();
      checks++;
      if (out_mask_o !== 2'b01 || got !== exp_p) begin
         failures++;
         $display("FAIL single_slot got=%h exp=%h", got, exp_p);
      end
      tick();
      idle();
   endtask

   task automatic test_reset_mid();
      for (int i = 60; i < 62; i++) begin
         put(1'b1, mk(i), 1'b0, 1'b0);
         tick();
      end
      put(1'b1, mk(62), 1'b1, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      idle();
      sb.delete();
      checks++;
      if (count_o !== 3'd0 || out_valid_o !== 1'b0 ||
          got !== pkt_t'('0)) begin
         failures++;
         $display("FAIL rst_mid got=%0d/%b/%h exp=0/0/0",
                  count_o, out_valid_o, got);
      end
      for (int i = 70; i < 72; i++) begin
         put(1'b1, mk(i), 1'b0, 1'b0);
         sb.push_back(mk(i));
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         put(1'b0, '0, 1'b1, 1'b0);
         exp_p = sb.pop_front();
         checks++;
         if (got !== exp_p) begin
            failures++;
            $display("FAIL rst_restart%0d got=%h exp=%h", i, got, exp_p);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_flush();
      test_bubble();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_pc_queue.md
Name: fetch_pc_queue

Overview:
- Decoupling FIFO directly downstream of the next-PC generator.
- Each cycle it accepts one fetch packet: up to two sequential PCs, a 2-bit valid mask and the branch-predictor metadata for that packet.
- It presents packets in order to the instruction-fetch stage (I-cache request side) through a valid/ready handshake.
- A redirect flush empties it in one cycle.

Parameters:
- DEPTH, 4, number of packet entries; power of two, at least 2.
- META_WIDTH, 64, width of the predictor metadata carried per packet (packed bpu_predict_t).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  redirect (backend correction or rst_jmp); discards all entries
- in_valid_i  in  1  packet offered by the next-PC stage
- in_pc_i  in  2x32  PCs of slot 0 and slot 1
- in_mask_i  in  2  slot valid mask; legal values 2'b01 and 2'b11
- in_meta_i  in  META_WIDTH  predictor metadata for the packet
- in_ready_o  out  1  queue can accept a packet this cycle
- out_valid_o  out  1  head packet available
- out_pc_o  out  2x32  head packet PCs
- out_mask_o  out  2  head packet mask
- out_meta_o  out  META_WIDTH  head packet metadata
- out_ready_i  in  1  fetch stage consumes the head this cycle
- count_o  out  clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Storage: DEPTH-entry circular buffer of {pc[1:0], mask, meta}.
  - Write pointer and read pointer are clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - Occupancy counter counts 0..DEPTH.
- Reset (rst_n=0 at posedge):
  - Pointers and count go to 0.
  - out_valid_o=0, in_ready_o=1, count_o=0.
  - Data outputs are don't-care, but the bench must see 0 after reset.
- Push condition: in_valid_i && in_ready_o && (in_mask_i != 2'b00) && !flush_i.
  - in_valid_i with mask 2'b00 is a bubble: ignored, no state change.
  - Mask 2'b10 is a protocol violation: simulation assertion fires; the entry is stored unchanged.
- Pop condition: out_valid_o && out_ready_i && !flush_i.
- in_ready_o = (count != DEPTH). It is a function of registered state only, with no combinational path from out_ready_i. A full queue refuses a push even when a pop happens in the same cycle.
- out_valid_o = (count != 0). The head fields are driven directly from the entry at the read pointer.
- Latency: a packet pushed in cycle N appears at the outputs in cycle N+1 at the earliest. There is no bypass.
- Simultaneous push and pop: both pointers advance and count is unchanged.
- Flush has highest priority:
  - At the posedge with flush_i=1, pointers and count clear to 0.
  - Any push or pop offered in that cycle is discarded.
  - Next cycle: out_valid_o=0, in_ready_o=1.
  - The outputs still show the old head during the flush cycle; the consumer must qualify them with flush_i.
- Reset overrides flush.
- Ordering: strictly FIFO. Slot 0 / slot 1 contents, mask and meta of an entry are never modified after being written.
- count_o equals the number of pushes minus pops since the last reset/flush, and never exceeds DEPTH.

Test Plan:
- Reset, then push one packet (pc 0x1c000000/0x1c000004, mask 2'b11, meta 0xA5) -> out_valid_o rises the next cycle with identical fields; count_o=1; pop -> count_o=0, out_valid_o=0.
- Push 4 packets with out_ready_i=0 (DEPTH=4) -> count_o=4, in_ready_o=0; a 5th offer is not stored; popping all returns the 4 packets in order.
- count_o=2 with push and pop in the same cycle, repeated 10 cycles -> count_o stays 2; output sequence matches input order; pointers wrap past index 3 without loss.
- Queue at count_o=3, flush_i=1 together with in_valid_i=1 and out_ready_i=1 -> next cycle count_o=0, out_valid_o=0, in_ready_o=1; the offered packet never appears.
- in_valid_i=1 with in_mask_i=2'b00 -> count_o unchanged; a single-slot packet with mask 2'b01 is stored and read back with mask 2'b01.
- Reset asserted while count_o=2 and a push is offered -> next cycle count_o=0, out_valid_o=0; later pushes start at entry 0.
